// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the RAM slave: bus widths, FSM encoding and
// the access legality check used when a request is latched.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_RESP = 3'b100
    } wb_state_e;

    // Range compare is done in 33 bits so a window ending at 2^32 cannot wrap.
    function automatic logic wb_access_err(
        input logic [WB_ADR_W-1:0] adr,
        input logic [WB_SEL_W-1:0] sel,
        input logic [WB_ADR_W-1:0] base,
        input logic [WB_ADR_W:0]   span_bytes
    );
        logic [WB_ADR_W:0] adr_ext;
        logic [WB_ADR_W:0] lo;
        logic [WB_ADR_W:0] hi;
        adr_ext = {1'b0, adr};
        lo      = {1'b0, base};
        hi      = lo + span_bytes;
        return (adr[1:0] != 2'b00) || (adr_ext < lo) || (adr_ext >= hi) ||
               (sel == '0);
    endfunction

endpackage

// File: rtl/wb_ram_bytewe.sv
// Synchronous single-port RAM, 32-bit words with per-byte write enables and a
// one-cycle read latency. Read data reflects the word before a same-cycle write.
module wb_ram_bytewe
    import wb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic [WB_SEL_W-1:0] we,
    input  logic [AW-1:0]       addr,
    input  logic [WB_DAT_W-1:0] wdata,
    output logic [WB_DAT_W-1:0] rdata
);

    logic [WB_DAT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int n = 0; n < WB_SEL_W; n++) begin
                if (we[n]) begin
                    mem[addr][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave wrapping a byte-writable RAM, with programmable wait
// states and err termination for misaligned, out-of-range or empty-select accesses.
//
// state | meaning
// IDLE  | waiting for cyc&stb; latches request and error flag
// WAIT  | counting wait states; dropping cyc/stb aborts the access
// RESP  | one-cycle ack or err; write committed, read data presented
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int                  DEPTH_WORDS = 1024,
    parameter int                  WAIT_STATES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic [WB_ADR_W-1:0] wbs_adr_i,
    input  logic [WB_DAT_W-1:0] wbs_dat_i,
    input  logic [WB_SEL_W-1:0] wbs_sel_i,
    input  logic                wbs_we_i,
    output logic [WB_DAT_W-1:0] wbs_dat_o,
    output logic                wbs_ack_o,
    output logic                wbs_err_o
);

    localparam int              AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WB_ADR_W:0] SPAN    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_state_e           state;
    logic [WB_ADR_W-1:0] adr_q;
    logic [WB_DAT_W-1:0] dat_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic                we_q;
    logic                err_q;
    logic [3:0]          wait_cnt;
    logic                ack_r;
    logic                err_r;
    logic [WB_DAT_W-1:0] dat_hold;

    logic                req;
    logic                req_err;
    logic                to_resp_idle;
    logic                to_resp_wait;
    logic                ram_en;
    logic [WB_SEL_W-1:0] ram_we;
    logic [AW-1:0]       ram_addr;
    logic [WB_DAT_W-1:0] ram_rdata;

    function automatic logic [AW-1:0] word_index(input logic [WB_ADR_W-1:0] a);
        return AW'((a - ADDR_BASE) >> 2);
    endfunction

    assign req          = wbs_cyc_i & wbs_stb_i;
    assign req_err      = wb_access_err(wbs_adr_i, wbs_sel_i, ADDR_BASE, SPAN);
    assign to_resp_idle = (state == ST_IDLE) && req && (WAIT_STATES == 0);
    assign to_resp_wait = (state == ST_WAIT) && req && (wait_cnt == 4'd0);

    // Reads are launched on the edge into RESP so rdata lands in the RESP cycle;
    // writes are committed at the end of RESP so a reset or abort earlier drops them.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = word_index(adr_q);
        if (to_resp_idle) begin
            ram_addr = word_index(wbs_adr_i);
            ram_en   = !req_err && !wbs_we_i;
        end else if (to_resp_wait) begin
            ram_en = !err_q && !we_q;
        end else if ((state == ST_RESP) && we_q && !err_q) begin
            ram_en = 1'b1;
            ram_we = sel_q;
        end
    end

    wb_ram_bytewe #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_i),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (dat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            dat_hold <= '0;
        end else begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        adr_q <= wbs_adr_i;
                        dat_q <= wbs_dat_i;
                        sel_q <= wbs_sel_i;
                        we_q  <= wbs_we_i;
                        err_q <= req_err;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                            ack_r <= !req_err;
                            err_r <= req_err;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                        ack_r <= !err_q;
                        err_r <= err_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (!we_q && !err_q) begin
                        dat_hold <= ram_rdata;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_r;
    assign wbs_err_o = err_r;
    // RAM output is only live in the RESP cycle of a good read; otherwise the
    // last successful read is held.
    assign wbs_dat_o = ((state == ST_RESP) && !we_q && !err_q) ? ram_rdata : dat_hold;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: directed scenarios with literal expectations plus
// randomized transfers checked every cycle against a transaction-level model.
module tb_wb_ram_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;
    localparam int          W     = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dati;
    logic [3:0]  sel;
    logic [31:0] dato;
    logic        ack, err;

    wb_ram_slave #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_adr_i (adr),
        .wbs_dat_i (dati),
        .wbs_sel_i (sel),
        .wbs_we_i  (we),
        .wbs_dat_o (dato),
        .wbs_ack_o (ack),
        .wbs_err_o (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Transaction-level model: memory array, one outstanding request, and the
    // cycle numbers at which it terminates and the next request may be taken.
    logic [31:0] mem_m [DEPTH];
    bit          pend = 0;
    longint      cyc_c = 0, resp_c = 0, next_acc = 0;
    bit          m_err, m_we;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [31:0] exp_dat = 0;

    function automatic bit model_err(input logic [31:0] a, input logic [3:0] s);
        longint la;
        la = longint'(a);
        return (la % 4 != 0) || (la < longint'(BASE)) ||
               (la >= longint'(BASE) + 4 * DEPTH) || (s == 4'd0);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    always @(negedge clk) begin : cmp
        bit in_resp;
        cyc_c++;
        if (!rst_n) begin
            pend     = 0;
            next_acc = 0;
            exp_dat  = 0;
            chk("rst_ack", {31'd0, ack}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_dat", dato, 32'd0);
        end else begin
            in_resp = pend && (cyc_c == resp_c);
            if (in_resp && !m_err && !m_we) exp_dat = mem_m[model_idx(m_adr)];
            chk("ack", {31'd0, ack}, {31'd0, in_resp && !m_err});
            chk("err", {31'd0, err}, {31'd0, in_resp && m_err});
            chk("dat", dato, exp_dat);
            if (in_resp) begin
                if (!m_err && m_we) begin
                    for (int n = 0; n < 4; n++)
                        if (m_sel[n]) mem_m[model_idx(m_adr)][8*n +: 8] = m_dat[8*n +: 8];
                end
                pend = 0;
            end else if (pend && !(cyc && stb)) begin
                pend     = 0;
                next_acc = cyc_c + 1;
            end else if (!pend && cyc_c >= next_acc && cyc && stb) begin
                m_adr    = adr;
                m_dat    = dati;
                m_sel    = sel;
                m_we     = we;
                m_err    = model_err(adr, sel);
                resp_c   = cyc_c + 1 + W;
                next_acc = resp_c + 1;
                pend     = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 of the request cycle; returns at posedge+1 of the
    // termination (or abort) cycle with the bus request dropped.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input int abort_k, input bit scramble,
                         output bit got_ack, output bit got_err,
                         output logic [31:0] rd, output int lat);
        adr = a; dati = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        got_ack = 0; got_err = 0; rd = '0; lat = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ack || err) begin
                got_ack = ack; got_err = err; rd = dato; lat = k;
                cyc = 1'b0; stb = 1'b0;
                return;
            end
            if (k == abort_k) begin
                stb = 1'b0;
                cyc = 1'($urandom_range(0, 1));
                return;
            end
            if (scramble) begin
                adr = $urandom; dati = $urandom; sel = 4'($urandom); we = 1'($urandom);
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout: no ack/err within 30 cycles, required termination");
        cyc = 1'b0; stb = 1'b0;
    endtask

    bit          ga, ge;
    logic [31:0] rd;
    int          lat;
    int          acks;
    int          cls;
    logic [31:0] ra;

    initial begin
        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; dati = 0; sel = 0;
        foreach (mem_m[i]) mem_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) begin
            issue(BASE + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, 1'b1, 0, 0, ga, ge, rd, lat);
            step();
        end

        // Scenario 1: full write then read
        issue(BASE + 8, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, ga, ge, rd, lat);
        chk("t1_wr_ack", {31'd0, ga}, 32'd1);
        chk("t1_wr_lat", lat, 32'd4);
        step();
        issue(BASE + 8, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t1_rd_lat", lat, 32'd4);
        chk("t1_rd_dat", rd, 32'hDEAD_BEEF);
        step();

        // Scenario 2: single byte lane
        issue(BASE + 8, 32'h00AA_0000, 4'b0100, 1'b1, 0, 0, ga, ge, rd, lat);
        step();
        issue(BASE + 8, 32'h0, 4'h1, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t2_rd_dat", rd, 32'hDEAA_BEEF);
        step();

        // Scenario 3: error terminations
        issue(BASE + 2, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 0, ga, ge, rd, lat);
        chk("t3_mis_err", {31'd0, ge}, 32'd1);
        chk("t3_mis_ack", {31'd0, ga}, 32'd0);
        step();
        chk("t3_err_pulse", {31'd0, err}, 32'd0);
        issue(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 0, ga, ge, rd, lat);
        chk("t3_oor_err", {31'd0, ge}, 32'd1);
        step();
        issue(BASE - 4, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t3_below_err", {31'd0, ge}, 32'd1);
        step();
        issue(BASE + 8, 32'hFFFF_FFFF, 4'h0, 1'b1, 0, 0, ga, ge, rd, lat);
        chk("t3_sel0_err", {31'd0, ge}, 32'd1);
        chk("t3_sel0_lat", lat, 32'd4);
        step();
        issue(BASE, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t3_rb_word0", rd, 32'hA5A5_0000);
        step();
        issue(BASE + 8, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t3_rb_word2", rd, 32'hDEAA_BEEF);
        step();
        issue(BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t3_last_word", rd, 32'hA5A5_003F);
        step();

        // Scenario 4: abort in the second wait cycle
        issue(BASE + 8, 32'h1111_1111, 4'hF, 1'b1, 2, 0, ga, ge, rd, lat);
        chk("t4_no_ack", {31'd0, ga}, 32'd0);
        chk("t4_no_err", {31'd0, ge}, 32'd0);
        step();
        issue(BASE + 8, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t4_idle_lat", lat, 32'd4);
        chk("t4_rb", rd, 32'hDEAA_BEEF);
        step();

        // Scenario 5: request held across two reads
        adr = BASE + 8; dati = 0; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ack) begin
                acks++;
                if (acks == 1) begin
                    chk("t5_ack1_cyc", k, 32'd4);
                    chk("t5_ack1_dat", dato, 32'hDEAA_BEEF);
                    adr = BASE;
                end else begin
                    chk("t5_ack2_cyc", k, 32'd9);
                    chk("t5_ack2_dat", dato, 32'hA5A5_0000);
                    break;
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        chk("t5_ack_count", acks, 32'd2);
        step();

        // Scenario 6: asynchronous reset mid-wait of a write
        issue(BASE + 16, 32'h1234_5678, 4'hF, 1'b1, 0, 0, ga, ge, rd, lat);
        step();
        issue(BASE + 16, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t6_pre_rd", rd, 32'h1234_5678);
        step();
        adr = BASE + 16; dati = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ack0", {31'd0, ack}, 32'd0);
        chk("t6_err0", {31'd0, err}, 32'd0);
        chk("t6_dat0", dato, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        issue(BASE + 16, 32'h0, 4'hF, 1'b0, 0, 0, ga, ge, rd, lat);
        chk("t6_rb", rd, 32'h1234_5678);
        step();

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            cls = $urandom_range(0, 7);
            if (cls <= 4)      ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            else if (cls == 5) ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            else if (cls == 6) ra = BASE - 32'(4 * $urandom_range(1, 8));
            else               ra = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            issue(ra, $urandom, 4'($urandom_range(0, 15)), 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(1, W) : 0,
                  1'($urandom_range(0, 1)), ga, ge, rd, lat);
            repeat ($urandom_range(1, 3)) step();
        end

        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
